// File: rtl/mux4x32_reg.sv
// mux4x32_reg: registered 4-to-1 word selector.
//
// Picks one of four WIDTH-bit words by a 2-bit select and presents it on a
// registered output, giving a clean, glitch-free result one clock after the
// inputs are sampled. Nothing combinational reaches y.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset (clears y, y_valid, y_par)
//   a0..a3  - data words, chosen by s = 00..11
//   s       - select
//   en      - capture enable; output registers load only when en = 1
//   y       - registered selected word (bit-exact copy)
//   y_valid - high once y holds a word captured since reset
//   y_par   - (MUX4X32_PARITY_EN only) XOR reduction of the captured word
//
// Build option:
//   MUX4X32_PARITY_EN - adds the y_par output, registered alongside y.

module mux4x32_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [1:0]       s,
`ifdef MUX4X32_PARITY_EN
  output logic             y_par,
`endif
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  // Gather the words so the 2-bit select indexes them directly; all four
  // codes map to a word, so there is no default arm to fall into.
  logic [3:0][WIDTH-1:0] a_vec;
  logic [WIDTH-1:0]      sel;

  always_comb begin
    a_vec = {a3, a2, a1, a0};
    sel   = a_vec[s];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else if (en) begin
      y       <= sel;
      y_valid <= 1'b1;
    end
  end

`ifdef MUX4X32_PARITY_EN
  // Even parity of the word being captured, so y_par always describes y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  y_par <= 1'b0;
    else if (en) y_par <= ^sel;
  end
`endif

endmodule

// File: tb/tb_mux4x32_reg.sv
// Directed bench for mux4x32_reg: reset, each select code, hold, latency and
// mid-stream reset, with hand-computed expected words.

module tb_mux4x32_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a0, a1, a2, a3;
  logic [1:0]  s;
  logic        en;
  logic [31:0] y;
  logic        y_valid;
`ifdef MUX4X32_PARITY_EN
  logic        y_par;
`endif

  int n_chk = 0;
  int n_err = 0;

  mux4x32_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .s(s),
`ifdef MUX4X32_PARITY_EN
    .y_par(y_par),
`endif
    .en(en), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive a vector on the falling edge, then sample 1 unit after the rise.
  task automatic drive(input logic e, input logic [1:0] sv,
                       input logic [31:0] v0, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] v3);
    @(negedge clk);
    en = e; s = sv; a0 = v0; a1 = v1; a2 = v2; a3 = v3;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; s = 2'b00;
    a0 = 32'hF000_0000; a1 = '0; a2 = '0; a3 = '0;

    // Async reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y_async", y, 32'h0);
    chk("rst_vld_async", {31'b0, y_valid}, 32'h0);
`ifdef MUX4X32_PARITY_EN
    chk("rst_par_async", {31'b0, y_par}, 32'h0);
`endif
    edge_wait();
    edge_wait();
    @(negedge clk);
    rst_n = 1'b1;
    edge_wait();
    chk("post_rel_y", y, 32'h0);
    chk("post_rel_vld", {31'b0, y_valid}, 32'h0);

    // Select 00.
    drive(1'b1, 2'b00, 32'hF000_0000, 32'h0, 32'hF000_0000, 32'h0);
    #1 chk("no_comb_path", y, 32'h0);
    edge_wait();
    chk("sel00_y", y, 32'hF000_0000);
    chk("sel00_vld", {31'b0, y_valid}, 32'h1);
`ifdef MUX4X32_PARITY_EN
    chk("sel00_par", {31'b0, y_par}, 32'h0);
`endif

    // Select 01.
    drive(1'b1, 2'b01, 32'hF000_0001, 32'h0000_0001, 32'h0, 32'h0);
    edge_wait();
    chk("sel01_y", y, 32'h0000_0001);

    // Select 10.
    drive(1'b1, 2'b10, 32'hF010_0000, 32'h0010_0000, 32'hF010_0000, 32'h0);
    edge_wait();
    chk("sel10_y", y, 32'hF010_0000);

    // Select 11.
    drive(1'b1, 2'b11, 32'hF000_00BA, 32'h0, 32'h0, 32'h0000_00BA);
    edge_wait();
    chk("sel11_y", y, 32'h0000_00BA);
`ifdef MUX4X32_PARITY_EN
    chk("sel11_par", {31'b0, y_par}, 32'h1);
`endif

    // Hold for 3 edges with en low and different inputs.
    drive(1'b0, 2'b00, 32'h0000_D000, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      chk($sformatf("hold_y%0d", i), y, 32'h0000_00BA);
    end
    chk("hold_vld", {31'b0, y_valid}, 32'h1);
`ifdef MUX4X32_PARITY_EN
    chk("hold_par", {31'b0, y_par}, 32'h1);
`endif
    drive(1'b1, 2'b00, 32'h0000_D000, 32'h0, 32'h0, 32'h0);
    edge_wait();
    chk("resume_y", y, 32'h0000_D000);

    // Mid-stream reset.
    drive(1'b1, 2'b00, 32'h1000_0000, 32'h0, 32'h0, 32'h0);
    edge_wait();
    chk("pre_mid_y", y, 32'h1000_0000);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_y", y, 32'h0);
    chk("mid_rst_vld", {31'b0, y_valid}, 32'h0);
    // Capture attempted while reset is held must be discarded.
    edge_wait();
    chk("rst_hold_y", y, 32'h0);
    chk("rst_hold_vld", {31'b0, y_valid}, 32'h0);
    drive(1'b1, 2'b10, 32'h0, 32'h0, 32'h0100_0000, 32'h0);
    rst_n = 1'b1;
    edge_wait();
    chk("post_mid_y", y, 32'h0100_0000);
    chk("post_mid_vld", {31'b0, y_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mux4x32_reg.md
Name: mux4x32_reg

Overview:
- Registered 4-to-1 word selector: picks one of four WIDTH-bit data words by a 2-bit select and presents it on a registered output.
- Used in datapath operand/writeback selection (e.g. PC-source or register-write-source choice) where a clean, glitch-free registered result is required.
- One clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 32, bit width of each data input and of the output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a0  input  WIDTH  data word, selected when s = 2'b00.
- a1  input  WIDTH  data word, selected when s = 2'b01.
- a2  input  WIDTH  data word, selected when s = 2'b10.
- a3  input  WIDTH  data word, selected when s = 2'b11.
- s  input  2  select.
- en  input  1  capture enable; the output register loads only when en = 1.
- y  output  WIDTH  registered selected word.
- y_valid  output  1  high when y holds a word captured since reset.

Behaviour:
- Reset: rst_n = 0 asynchronously forces y = 0 and y_valid = 0, independent of clk; both hold while rst_n is low.
- Release of rst_n takes effect at the next rising clk edge; no capture happens on the release edge unless rst_n is already high at that edge.
- Selection is a full decode, so there is no default or X case:
  - s = 00 -> a0
  - s = 01 -> a1
  - s = 10 -> a2
  - s = 11 -> a3
- Capture: on a rising clk edge with rst_n = 1 and en = 1, y <= selected word and y_valid <= 1.
- Hold: with en = 0, y and y_valid keep their values.
- Latency: exactly 1 clock from the sampled inputs and s to y. There is no combinational path from any input to y.
- Inputs and s change freely between edges; only the values at the rising edge matter.
- Reset asserted mid-operation overrides everything; any pending capture is discarded.
- Widths: no arithmetic. y is a bit-exact copy of the selected input; no sign or zero extension.
- X on s at a capture edge: the result is undefined; the verifier does not check it.

Optional Feature:
- Macro: MUX4X32_PARITY_EN.
- Defined:
  - Adds output port y_par, 1 bit.
  - y_par is registered alongside y and equals the XOR reduction of the selected word (even parity).
  - Reset value 0; holds when en = 0.
- Undefined: the y_par port does not exist; all other behaviour is identical.

Test Plan:
- Reset: rst_n = 0 with a0 = F0000000 -> y = 00000000 and y_valid = 0 immediately, without a clock edge; still 0 after release until the first en = 1 edge.
- Select 00: en = 1, s = 00, a0 = F0000000, a1 = 00000000, a2 = F0000000, a3 = 00000000 -> after 1 edge y = F0000000, y_valid = 1; with parity, y_par = 0.
- Select 01 and 10:
  - a0 = F0000001, a1 = 00000001, s = 01 -> y = 00000001.
  - a0 = F0100000, a2 = F0100000, a1 = 00100000, s = 10 -> y = F0100000.
- Select 11: a0 = F00000BA, a3 = 000000BA, s = 11 -> y = 000000BA; with parity, y_par = 1.
- Hold: after y = 000000BA, set en = 0 and change to s = 00, a0 = 0000D000 for 3 edges -> y stays 000000BA. Set en = 1 -> y = 0000D000 one edge later.
- Reset mid-stream: y = 10000000 and rst_n pulses low between edges -> y = 0 and y_valid = 0 at once. The next edge with en = 1, s = 10, a2 = 01000000 -> y = 01000000.
